// File: rtl/if_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch front-end and writer side of the IF/ID
//               register. Owns the fetch PC, issues in-order memory requests,
//               buffers returned words with their PCs and handles stall and
//               branch/jump redirects. Optional macro FETCH_BYPASS_EN presents
//               a response in its arrival cycle when the buffer is empty.
// Revision    : 1.0 - initial release
// =============================================================================
module if_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [31:0]     i_imem_rsp_data,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_pc_out,
    output logic [31:0]     o_instr_out,
    output logic            o_instr_valid
);

    localparam int          c_AW       = $clog2(DEPTH);
    localparam int          c_CW       = c_AW + 1;
    localparam logic [c_CW:0] c_DEPTH  = (c_CW + 1)'(DEPTH);
    localparam logic [31:0] c_NOP      = 32'h00000013;
    localparam logic [0:0]  c_ST_FETCH = 1'b0;
    localparam logic [0:0]  c_ST_DRAIN = 1'b1;

    // Fetch PC and in-flight PC queue
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pcq [DEPTH];
    logic [c_AW-1:0] r_pcq_wr;
    logic [c_AW-1:0] r_pcq_rd;
    logic [c_CW-1:0] r_outstanding;

    // Instruction buffer
    logic [XLEN-1:0] r_buf_pc    [DEPTH];
    logic [31:0]     r_buf_instr [DEPTH];
    logic [c_AW-1:0] r_buf_wr;
    logic [c_AW-1:0] r_buf_rd;
    logic [c_CW-1:0] r_occ;
    logic [XLEN-1:0] r_pc_hold;

    // Redirect drain control
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_CW-1:0] r_drop_cnt;
    logic [c_CW-1:0] w_drop_nxt;

    logic [c_CW:0]   w_inflight;
    logic            w_in_fetch;
    logic            w_acc;
    logic            w_rsp;
    logic            w_rsp_keep;
    logic            w_buf_empty;
    logic            w_bypass;
    logic            w_buf_push;
    logic            w_buf_pop;

    assign w_inflight      = {1'b0, r_outstanding} + {1'b0, r_occ};
    assign w_acc           = o_imem_req_valid && i_imem_req_ready;
    // A response with nothing outstanding cannot belong to us and is ignored.
    assign w_rsp           = i_imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_keep      = w_rsp && w_in_fetch && !i_redirect_valid;
    assign w_buf_empty     = (r_occ == '0);
    assign o_imem_req_addr = r_fetch_pc;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_rsp_keep && w_buf_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that ID accepts immediately never touches the buffer.
    assign w_buf_push = w_rsp_keep && !(w_bypass && !i_stall);
    assign w_buf_pop  = o_instr_valid && !i_stall && !i_redirect_valid && !w_buf_empty;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_FETCH;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop_cnt;
        if (i_redirect_valid) begin
            // Every outstanding request is now stale, including one answered this cycle.
            w_drop_nxt  = r_outstanding - c_CW'(w_rsp);
            w_state_nxt = (w_drop_nxt != '0) ? c_ST_DRAIN : c_ST_FETCH;
        end else if ((r_state == c_ST_DRAIN) && w_rsp) begin
            w_drop_nxt = r_drop_cnt - c_CW'(1);
            if (w_drop_nxt == '0) begin
                w_state_nxt = c_ST_FETCH;
            end
        end
    end

    // ----------------------------------------------------------------- outputs
    always_comb begin
        w_in_fetch       = (r_state == c_ST_FETCH);
        o_imem_req_valid = !reset && !i_redirect_valid && (w_inflight < c_DEPTH);
        o_pc_out         = r_pc_hold;
        o_instr_out      = c_NOP;
        o_instr_valid    = 1'b0;
        if (reset) begin
            o_pc_out = '0;
        end else if (!w_buf_empty) begin
            o_pc_out      = r_buf_pc[r_buf_rd];
            o_instr_out   = r_buf_instr[r_buf_rd];
            o_instr_valid = 1'b1;
        end else if (w_bypass) begin
            o_pc_out      = r_pcq[r_pcq_rd];
            o_instr_out   = i_imem_rsp_data;
            o_instr_valid = 1'b1;
        end
    end

    // ------------------------------------------------------ pointers / counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
            r_outstanding <= '0;
            r_buf_wr      <= '0;
            r_buf_rd      <= '0;
            r_occ         <= '0;
            r_pc_hold     <= '0;
        end else begin
            if (i_redirect_valid) begin
                r_fetch_pc <= i_redirect_pc;
            end else if (w_acc) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end

            if (w_acc) begin
                r_pcq_wr <= r_pcq_wr + c_AW'(1);
            end
            if (w_rsp) begin
                r_pcq_rd <= r_pcq_rd + c_AW'(1);
            end
            r_outstanding <= r_outstanding + c_CW'(w_acc) - c_CW'(w_rsp);

            if (i_redirect_valid) begin
                r_buf_rd <= r_buf_wr;
                r_occ    <= '0;
            end else begin
                if (w_buf_push) begin
                    r_buf_wr <= r_buf_wr + c_AW'(1);
                end
                if (w_buf_pop) begin
                    r_buf_rd <= r_buf_rd + c_AW'(1);
                end
                r_occ <= r_occ + c_CW'(w_buf_push) - c_CW'(w_buf_pop);
            end

            if (o_instr_valid) begin
                r_pc_hold <= o_pc_out;
            end
        end
    end

    // ------------------------------------------------------------ storage arrays
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        end
        if (w_buf_push) begin
            r_buf_pc[r_buf_wr]    <= r_pcq[r_pcq_rd];
            r_buf_instr[r_buf_wr] <= i_imem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit with an in-order
//               latency-1 instruction memory whose word is {16'hA5A5, addr[15:0]}.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;

    logic        hold;
    int          errors = 0;
    int          checks = 0;

    logic [63:0] memq[$];
    logic [63:0] acc_log[$];
    logic [63:0] pres_pc[$];
    logic [31:0] pres_instr[$];

    if_fetch_unit #(.XLEN(64), .RESET_PC(64'h1000), .DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .o_imem_req_valid (imem_req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_req_addr  (imem_req_addr),
        .i_imem_rsp_valid (imem_rsp_valid),
        .i_imem_rsp_data  (imem_rsp_data),
        .i_stall          (stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_pc_out         (pc_out),
        .o_instr_out      (instr_out),
        .o_instr_valid    (instr_valid)
    );

    always #5 clk = ~clk;

    // Memory: accepted requests queue up and the head answers the next cycle.
    always @(negedge clk) begin
        logic [63:0] a;
        if (!reset && !hold && memq.size() > 0) begin
            a = memq[0];
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {16'hA5A5, a[15:0]};
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    always @(posedge clk) begin
        logic [63:0] t;
        if (reset) begin
            memq.delete();
        end else begin
            if (imem_rsp_valid && memq.size() > 0) t = memq.pop_front();
            if (imem_req_valid && imem_req_ready) begin
                memq.push_back(imem_req_addr);
                acc_log.push_back(imem_req_addr);
            end
            if (instr_valid && !stall && !redirect_valid) begin
                pres_pc.push_back(pc_out);
                pres_instr.push_back(instr_out);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pres(input int n, input string name);
        int k = 0;
        while (pres_pc.size() < n && k < 60) begin
            step();
            k++;
        end
        checks++;
        if (pres_pc.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d presented, want %0d", name, pres_pc.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; hold = 1'b0;
        step(); step();
        mid();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
        checks++; if (instr_out !== c_NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instr_out, c_NOP); end
        checks++; if (pc_out !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_out); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b want 0", imem_req_valid); end
        step();
        reset = 1'b0;
        acc_log.delete(); pres_pc.delete(); pres_instr.delete();
    endtask

    task automatic test_basic();
        logic [63:0] e_pc [3];
        logic [31:0] e_in [3];
        e_pc[0] = 64'h1000; e_pc[1] = 64'h1004; e_pc[2] = 64'h1008;
        e_in[0] = 32'hA5A51000; e_in[1] = 32'hA5A51004; e_in[2] = 32'hA5A51008;
        wait_pres(3, "basic");
        if (pres_pc.size() >= 3) begin
            checks++;
            if (acc_log[0] !== 64'h1000) begin errors++; $display("FAIL basic_first_addr: got %h want 1000", acc_log[0]); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pres_pc[i] !== e_pc[i]) begin errors++; $display("FAIL basic_pc[%0d]: got %h want %h", i, pres_pc[i], e_pc[i]); end
                checks++;
                if (pres_instr[i] !== e_in[i]) begin errors++; $display("FAIL basic_instr[%0d]: got %h want %h", i, pres_instr[i], e_in[i]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] held_pc;
        logic [31:0] held_instr;
        int n0;
        stall = 1'b1;
        repeat (4) step();
        mid();
        held_pc = pc_out; held_instr = instr_out;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_full_valid: got %0b want 1", instr_valid); end
        checks++; if (dut.r_occ !== 2'd2) begin errors++; $display("FAIL stall_full_occ: got %0d want 2", dut.r_occ); end
        for (int i = 0; i < 5; i++) begin
            step(); mid();
            checks++; if (pc_out !== held_pc) begin errors++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc_out, held_pc); end
            checks++; if (instr_out !== held_instr) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr_out, held_instr); end
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid[%0d]: got %0b want 0", i, imem_req_valid); end
        end
        step();
        n0 = pres_pc.size();
        stall = 1'b0;
        wait_pres(n0 + 4, "stall_resume");
        if (pres_pc.size() >= n0 + 4) begin
            checks++; if (pres_pc[n0] !== held_pc) begin errors++; $display("FAIL stall_resume_pc: got %h want %h", pres_pc[n0], held_pc); end
            checks++; if (pres_instr[n0] !== held_instr) begin errors++; $display("FAIL stall_resume_instr: got %h want %h", pres_instr[n0], held_instr); end
        end
        for (int i = 1; i < pres_pc.size(); i++) begin
            checks++;
            if (pres_pc[i] !== pres_pc[i-1] + 64'd4) begin errors++; $display("FAIL stall_seq[%0d]: got %h want %h", i, pres_pc[i], pres_pc[i-1] + 64'd4); end
        end
    endtask

    task automatic test_redirect();
        logic [63:0] stale0, stale1;
        hold = 1'b1;
        repeat (5) step();
        mid();
        checks++; if (dut.r_outstanding !== 2'd2) begin errors++; $display("FAIL redir_outstanding: got %0d want 2", dut.r_outstanding); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_pre_valid: got %0b want 0", instr_valid); end
        stale0 = (memq.size() > 0) ? memq[0] : 64'h1;
        stale1 = (memq.size() > 1) ? memq[1] : 64'h1;
        step();
        pres_pc.delete(); pres_instr.delete();
        redirect_valid = 1'b1; redirect_pc = 64'h2000;
        mid();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_valid: got %0b want 0", imem_req_valid); end
        step();
        redirect_valid = 1'b0; hold = 1'b0;
        mid();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_post_valid: got %0b want 0", instr_valid); end
        checks++; if (dut.r_drop_cnt !== 2'd2) begin errors++; $display("FAIL redir_drop_cnt: got %0d want 2", dut.r_drop_cnt); end
        wait_pres(2, "redir");
        if (pres_pc.size() >= 2) begin
            checks++; if (pres_pc[0] !== 64'h2000) begin errors++; $display("FAIL redir_pc0: got %h want 2000", pres_pc[0]); end
            checks++; if (pres_instr[0] !== 32'hA5A52000) begin errors++; $display("FAIL redir_instr0: got %h want A5A52000", pres_instr[0]); end
            checks++; if (pres_pc[1] !== 64'h2004) begin errors++; $display("FAIL redir_pc1: got %h want 2004", pres_pc[1]); end
        end
        for (int i = 0; i < pres_pc.size(); i++) begin
            checks++;
            if (pres_pc[i] === stale0 || pres_pc[i] === stale1) begin errors++; $display("FAIL redir_stale[%0d]: got %h want not %h/%h", i, pres_pc[i], stale0, stale1); end
        end
    endtask

    task automatic test_redirect_rsp_stall();
        hold = 1'b1;
        repeat (5) step();
        mid();
        checks++; if (dut.r_outstanding !== 2'd2) begin errors++; $display("FAIL rsr_outstanding: got %0d want 2", dut.r_outstanding); end
        step();
        pres_pc.delete(); pres_instr.delete();
        redirect_valid = 1'b1; redirect_pc = 64'h3000; stall = 1'b1; hold = 1'b0;
        mid();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rsr_req_valid: got %0b want 0", imem_req_valid); end
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        mid();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rsr_valid: got %0b want 0", instr_valid); end
        checks++; if (instr_out !== c_NOP) begin errors++; $display("FAIL rsr_instr: got %h want %h", instr_out, c_NOP); end
        checks++; if (dut.r_drop_cnt !== 2'd1) begin errors++; $display("FAIL rsr_drop_cnt: got %0d want 1", dut.r_drop_cnt); end
        wait_pres(1, "rsr");
        if (pres_pc.size() >= 1) begin
            checks++; if (pres_pc[0] !== 64'h3000) begin errors++; $display("FAIL rsr_pc0: got %h want 3000", pres_pc[0]); end
            checks++; if (pres_instr[0] !== 32'hA5A53000) begin errors++; $display("FAIL rsr_instr0: got %h want A5A53000", pres_instr[0]); end
        end
    endtask

    task automatic test_wrap();
        step();
        acc_log.delete(); pres_pc.delete(); pres_instr.delete();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_pres(2, "wrap");
        if (pres_pc.size() >= 2 && acc_log.size() >= 2) begin
            checks++; if (acc_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h want FFFFFFFFFFFFFFFC", acc_log[0]); end
            checks++; if (acc_log[1] !== 64'h0) begin errors++; $display("FAIL wrap_addr1: got %h want 0", acc_log[1]); end
            checks++; if (pres_pc[1] !== 64'h0) begin errors++; $display("FAIL wrap_pc1: got %h want 0", pres_pc[1]); end
            checks++; if (pres_instr[0] !== 32'hA5A5FFFC) begin errors++; $display("FAIL wrap_instr0: got %h want A5A5FFFC", pres_instr[0]); end
            checks++; if (pres_instr[1] !== 32'hA5A50000) begin errors++; $display("FAIL wrap_instr1: got %h want A5A50000", pres_instr[1]); end
        end
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        repeat (4) step();
        mid();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rmid_full_valid: got %0b want 1", instr_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_full_req: got %0b want 0", imem_req_valid); end
        step();
        reset = 1'b1;
        mid();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_req_in_reset: got %0b want 0", imem_req_valid); end
        step();
        reset = 1'b0; stall = 1'b0;
        acc_log.delete(); pres_pc.delete(); pres_instr.delete();
        mid();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b want 0", instr_valid); end
        checks++; if (instr_out !== c_NOP) begin errors++; $display("FAIL rmid_instr: got %h want %h", instr_out, c_NOP); end
        checks++; if (pc_out !== 64'h0) begin errors++; $display("FAIL rmid_pc: got %h want 0", pc_out); end
        wait_pres(1, "rmid");
        if (acc_log.size() >= 1 && pres_pc.size() >= 1) begin
            checks++; if (acc_log[0] !== 64'h1000) begin errors++; $display("FAIL rmid_first_addr: got %h want 1000", acc_log[0]); end
            checks++; if (pres_pc[0] !== 64'h1000) begin errors++; $display("FAIL rmid_first_pc: got %h want 1000", pres_pc[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_redirect_rsp_stall();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
